// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer between the instruction memory port and the IFU.
// One fetch at a time; handles decode back-pressure, redirects, alignment, bus errors and timeout.
module fetch_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  ifc_clock_in,
  input  logic                  ifc_reset_in,
  input  logic                  fetch_en_in,
  input  logic [ADDR_WIDTH-1:0] pc_addr_in,
  input  logic                  dec_ready_in,
  input  logic                  redirect_in,
  output logic                  redirect_ack_out,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_ack_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_err_in,
  output logic [DATA_WIDTH-1:0] ir_data_out,
  output logic                  ir_set_out,
  output logic                  pc_set_out,
  output logic                  busy_out,
  output logic                  fault_out,
  output logic [1:0]            fault_code_out
);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, HOLD, DROP, REDIR, FAULT} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] CODE_BUS = 2'b01;
  localparam logic [1:0] CODE_TO  = 2'b10;
  localparam logic [1:0] CODE_MIS = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] code_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       timeout;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Strobe pattern {mem_req, busy, ir_set, pc_set, redirect_ack} for the state being entered.
  function automatic logic [4:0] strobes(input state_t s);
    case (s)
      REQ, DROP: return 5'b11000;
      LOAD:      return 5'b01110;
      HOLD:      return 5'b01000;
      REDIR:     return 5'b01011;
      FAULT:     return 5'b01000;
      default:   return 5'b00000;
    endcase
  endfunction

  always_comb begin
    wait_inc  = sat_inc(wait_cnt);
    timeout   = (wait_inc == TO_LIMIT);
    state_nxt = state;
    code_nxt  = 2'b00;
    case (state)
      IDLE, HOLD: begin
        if (redirect_in) begin
          state_nxt = REDIR;
        end else if (fetch_en_in && dec_ready_in) begin
          if (pc_addr_in[1:0] != 2'b00) begin
            state_nxt = FAULT;
            code_nxt  = CODE_MIS;
          end else begin
            state_nxt = REQ;
          end
        end else if (state == HOLD && !fetch_en_in) begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_ack_in) begin
          if (mem_err_in) begin
            state_nxt = FAULT;
            code_nxt  = CODE_BUS;
          end else if (redirect_in) begin
            state_nxt = REDIR;
          end else begin
            state_nxt = LOAD;
          end
        // Timeout is checked before redirect so a late redirect cannot carry the counter past the limit.
        end else if (timeout) begin
          state_nxt = FAULT;
          code_nxt  = CODE_TO;
        end else if (redirect_in) begin
          state_nxt = DROP;
        end
      end
      LOAD:  state_nxt = HOLD;
      DROP: begin
        if (mem_ack_in) begin
          state_nxt = REDIR;
        end else if (timeout) begin
          state_nxt = FAULT;
          code_nxt  = CODE_TO;
        end
      end
      REDIR: state_nxt = IDLE;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ifc_clock_in or negedge ifc_reset_in) begin
    if (!ifc_reset_in) begin
      state            <= IDLE;
      mem_req_out      <= 1'b0;
      busy_out         <= 1'b0;
      ir_set_out       <= 1'b0;
      pc_set_out       <= 1'b0;
      redirect_ack_out <= 1'b0;
      fault_out        <= 1'b0;
      fault_code_out   <= 2'b00;
      mem_addr_out     <= '0;
      ir_data_out      <= '0;
      wait_cnt         <= 8'd0;
    end else begin
      state <= state_nxt;
      {mem_req_out, busy_out, ir_set_out, pc_set_out, redirect_ack_out} <= strobes(state_nxt);
      if (state_nxt == REQ && state != REQ) begin
        wait_cnt     <= 8'd0;
        mem_addr_out <= pc_addr_in;
      end else if ((state == REQ || state == DROP) && !mem_ack_in) begin
        wait_cnt <= wait_inc;
      end
      if (state == REQ && mem_ack_in && !mem_err_in && !redirect_in) begin
        ir_data_out <= mem_data_in;
      end
      if (state_nxt == FAULT && state != FAULT) begin
        fault_out      <= 1'b1;
        fault_code_out <= code_nxt;
      end
    end
  end

endmodule
